dff_bist: RTL and testbench
===========================

# dff_bist

Built-in self-test driver/monitor for a single-bit D flip-flop cell under test. It drives the cell's D input with an 8-bit LFSR pseudo-random sequence on the shared clock and samples the cell's Q output. It compares Q against a one-cycle-delayed golden model of the drive stream, counts mismatches and reports pass/fail. It is the stimulus and response end of the flip-flop interface and lets cell characterisation run on silicon without an external tester.

## Interface
- `SEED`, default 8'h01: LFSR load value. Must be nonzero.
- `NUM_BITS`, default 32: number of pseudo-random bits driven per test, 1..65535.
- `ERR_W`, default 8: width of the mismatch counter.

Ports:
- `clk`  in  1  single clock. The cell under test uses the same clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a test. Ignored while `busy`.
- `dut_d`  out  1  registered drive to the cell's D input.
- `dut_q`  in  1  the cell's Q output.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse marking the end of a test.
- `pass`  out  1  1 when the last test had zero mismatches. Valid with `done` and held until the next start.
- `err_count`  out  ERR_W  number of mismatches, saturating.
- `first_err_idx`  out  16  index of the first mismatching bit. 16'hFFFF if there was none.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- The FSM is in IDLE after reset.
- Reset values of the outputs:
  - `dut_d`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `first_err_idx`=16'hFFFF.
- IDLE → RUN when `start`=1.
  - On that edge the LFSR loads `SEED` and the bit index counter clears.
  - `err_count` clears to 0 and `first_err_idx` sets to 16'hFFFF.
- RUN lasts NUM_BITS cycles.
  - In each cycle `dut_d` = `lfsr[0]` and the LFSR steps.
  - LFSR step: `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
- DRAIN lasts exactly 2 cycles with `dut_d`=0, to flush the last compares.
- DONE lasts 1 cycle.
  - `done`=1 and `pass`=(`err_count`==0).
  - The FSM then returns to IDLE.
- Golden model:
  - `exp` is a register loaded from `dut_d` every edge.
  - A 2-deep valid pipeline is tagged only for RUN-driven bits.
  - When the valid bit is set, `dut_q`≠`exp` counts as a mismatch for bit index k.
- On a mismatch:
  - `err_count` increments, saturating at 2^ERR_W−1.
  - `first_err_idx` captures k if it is still 16'hFFFF.
- `dut_q` before the first valid compare, and during DRAIN-driven bits, is never compared. X values present out of reset are therefore ignored.
- `start` asserted during RUN, DRAIN or DONE has no effect.
- `rst_n` low mid-test aborts at once:
  - All state and outputs return to reset values.
  - No `done` pulse is issued.

## Timing
- Let edge 0 be the edge that samples `start`=1.
- RUN occupies the cycles following edges 1..NUM_BITS. Bit k is driven after edge k+1.
- The cell captures bit k at edge k+2. The BIST compares bit k at edge k+3.
- Compares occur on edges 3..NUM_BITS+2. The last compare falls in the first DRAIN cycle.
- `done` is high for exactly one cycle, registered at edge NUM_BITS+3. `busy` drops on the same edge.
- `err_count` and `first_err_idx` update on the compare edge itself.
- `err_count` is final at edge NUM_BITS+2.
- A new `start` is accepted in the cycle after `done`, at the earliest.

## Configuration
- `DFF_BIST_INJECT_EN` defined:
  - Adds input port `inject` (1 bit), placed after `start`.
  - When `inject`=1 in a RUN cycle, the golden bit for that cycle's drive is inverted. This forces exactly one mismatch per injected cycle against a good cell, so the checker itself can be tested.
- `DFF_BIST_INJECT_EN` undefined:
  - The port is absent and there is no inversion logic.

## Test plan
- Ideal DFF model on the same clock, defaults, `start` pulse:
  - `done` is high exactly at edge 35.
  - `pass`=1, `err_count`=0, `first_err_idx`=16'hFFFF.
- Cell modelled as Q=~D registered, defaults:
  - `err_count`=32, `pass`=0, `first_err_idx`=0.
- Same inverting cell with `ERR_W`=4:
  - `err_count` saturates at 15, `pass`=0.
- Q stuck-at-0:
  - `first_err_idx`=0, since the first driven bit is `SEED[0]`=1.
  - `err_count` equals the number of ones in the bench's reference LFSR sequence for 32 bits.
- `rst_n` pulsed low at edge 10 of a test:
  - All outputs read reset values immediately. No `done` pulse.
  - `start` 3 cycles later runs a clean test with `pass`=1.
- With `DFF_BIST_INJECT_EN`, ideal cell, `inject` high during RUN bits 5 and 9:
  - `err_count`=2, `first_err_idx`=5, `pass`=0.
- Additional check: a second `start` pulse during RUN is ignored, and `done` timing is unchanged.

Source files
------------

// File: rtl/dff_bist.sv
// BIST driver/monitor for one D flip-flop cell: LFSR drive, one-cycle-delayed golden compare.
// Optional DFF_BIST_INJECT_EN adds an `inject` input that inverts the golden bit for self-test.
`timescale 1ns/1ps
module dff_bist #(
  parameter logic [7:0] SEED     = 8'h01,
  parameter int         NUM_BITS = 32,
  parameter int         ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DFF_BIST_INJECT_EN
  input  logic             inject,
`endif
  output logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [15:0]        idx_q, idx_d;
  logic               drn_q, drn_d;
  logic               dut_d_q, drive_d;
  logic               exp_q, exp_d;
  logic [2:1]         vld_pipe_q;
  logic               run_bit;
  logic [15:0]        kp1_q, kp2_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [15:0]        ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
`ifdef DFF_BIST_INJECT_EN
  logic               inv_q, inv_d;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    drn_d   = drn_q;
    drive_d = 1'b0;
    run_bit = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
`ifdef DFF_BIST_INJECT_EN
    inv_d   = 1'b0;
    exp_d   = dut_d_q ^ inv_q;
`else
    exp_d   = dut_d_q;
`endif

    // Bit k is compared two edges after it was driven, against the registered drive.
    if (vld_pipe_q[2] && (dut_q != exp_q)) begin
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
      if (ferr_q == 16'hFFFF)     ferr_d = kp2_q;
    end

    case (state_q)
      IDLE: begin
        // done_q gates start so a new test begins no earlier than the cycle after done.
        if (start && !done_q) begin
          state_d = RUN;
          lfsr_d  = SEED;
          idx_d   = 16'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          ferr_d  = 16'hFFFF;
        end
      end
      RUN: begin
        drive_d = lfsr_q[0];
        run_bit = 1'b1;
`ifdef DFF_BIST_INJECT_EN
        inv_d   = inject;
`endif
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        idx_d   = idx_q + 16'd1;
        if (idx_q == 16'(NUM_BITS - 1)) begin
          state_d = DRAIN;
          drn_d   = 1'b0;
        end
      end
      DRAIN: begin
        drn_d = ~drn_q;
        if (drn_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      idx_q      <= 16'd0;
      drn_q      <= 1'b0;
      dut_d_q    <= 1'b0;
      exp_q      <= 1'b0;
      vld_pipe_q <= '0;
      kp1_q      <= 16'd0;
      kp2_q      <= 16'd0;
      err_q      <= '0;
      ferr_q     <= 16'hFFFF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef DFF_BIST_INJECT_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      drn_q      <= drn_d;
      dut_d_q    <= drive_d;
      exp_q      <= exp_d;
      vld_pipe_q <= {vld_pipe_q[1], run_bit};
      kp1_q      <= idx_q;
      kp2_q      <= kp1_q;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
`ifdef DFF_BIST_INJECT_EN
      inv_q      <= inv_d;
`endif
    end
  end

  assign dut_d         = dut_d_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_dff_bist.sv
// Bench for dff_bist: cell models (ideal, inverting, stuck-at-0, random flips) vs. a sequence-level model.
`timescale 1ns/1ps
module tb_dff_bist;

  localparam logic [7:0] SEED = 8'h01;
  localparam int         NB   = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic dut_d, dut_q, busy, done, pass;
  logic [7:0]  err_count;
  logic [15:0] first_err_idx;
  logic d4, busy4, done4, pass4;
  logic [3:0]  err4;
  logic [15:0] fidx4;
`ifdef DFF_BIST_INJECT_EN
  logic        inject = 1'b0;
  logic [31:0] imask  = '0;
`endif

  int   mode = 0;           // 0 ideal (+flip_now), 1 inverting, 2 stuck-at-0
  logic flip_now = 1'b0;
  logic cq;
  int   tests_run = 0, fails = 0;

  // Run observations
  int          done_edge, ndone;
  logic [31:0] dseq;
  logic        r_pass, r_pass4, b34, b35;
  logic [7:0]  r_err;
  logic [3:0]  r_err4;
  logic [15:0] r_fidx;

  always #5 clk = ~clk;

  always @(posedge clk) cq <= (mode == 1) ? ~dut_d : (dut_d ^ flip_now);
  assign dut_q = (mode == 2) ? 1'b0 : cq;

  dff_bist #(.SEED(SEED), .NUM_BITS(NB), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DFF_BIST_INJECT_EN
    .inject(inject),
`endif
    .dut_d(dut_d), .dut_q(dut_q), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx));

  dff_bist #(.SEED(SEED), .NUM_BITS(NB), .ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DFF_BIST_INJECT_EN
    .inject(inject),
`endif
    .dut_d(d4), .dut_q(dut_q), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_err_idx(fidx4));

  // Reference drive stream: bit k is bit 0 of the LFSR after k steps from SEED.
  function automatic logic [31:0] ref_seq();
    logic [31:0] r;
    int s;
    r = '0;
    s = int'(SEED);
    for (int k = 0; k < NB; k++) begin
      r[k] = (s % 2 == 1);
      s = ((s * 2) % 256) + ((((s / 128) + (s / 32) + (s / 16) + (s / 8)) % 2));
    end
    return r;
  endfunction

  function automatic int popc(input logic [31:0] v);
    int c = 0;
    for (int k = 0; k < 32; k++) if (v[k]) c++;
    return c;
  endfunction

  // Drive one test; edge e is the e-th posedge after the one sampling start.
  task automatic run_test(input logic [31:0] fm, input bit extra_start);
    done_edge = -1; ndone = 0; dseq = '0; b34 = 1'b0; b35 = 1'b1;
    r_pass = 1'b0; r_pass4 = 1'b0; r_err = '0; r_err4 = '0; r_fidx = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      flip_now = (e >= 2 && e <= NB + 1) ? fm[e-2] : 1'b0;
`ifdef DFF_BIST_INJECT_EN
      inject = (e >= 1 && e <= NB) ? imask[e-1] : 1'b0;
`endif
      start = extra_start && (e == 10);
      @(posedge clk);
      @(negedge clk);
      if (e >= 1 && e <= NB) dseq[e-1] = dut_d;
      if (e == 34) b34 = busy;
      if (e == 35) b35 = busy;
      if (done) begin
        ndone++;
        if (done_edge < 0) begin
          done_edge = e; r_pass = pass; r_err = err_count; r_fidx = first_err_idx;
          r_pass4 = pass4; r_err4 = err4;
        end
      end
    end
    flip_now = 1'b0; start = 1'b0;
`ifdef DFF_BIST_INJECT_EN
    inject = 1'b0;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (dut_d !== 1'b0) begin fails++; $display("FAIL reset_dut_d got %b want 0", dut_d); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass got %b want 0", pass); end
    tests_run++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err got %0d want 0", err_count); end
    tests_run++; if (first_err_idx !== 16'hFFFF) begin fails++; $display("FAIL reset_fidx got %h want ffff", first_err_idx); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal();
    mode = 0;
    run_test('0, 1'b0);
    tests_run++; if (done_edge !== 35) begin fails++; $display("FAIL ideal_done_edge got %0d want 35", done_edge); end
    tests_run++; if (ndone !== 1) begin fails++; $display("FAIL ideal_ndone got %0d want 1", ndone); end
    tests_run++; if (dseq !== ref_seq()) begin fails++; $display("FAIL ideal_dseq got %h want %h", dseq, ref_seq()); end
    tests_run++; if (r_pass !== 1'b1) begin fails++; $display("FAIL ideal_pass got %b want 1", r_pass); end
    tests_run++; if (r_err !== 8'd0) begin fails++; $display("FAIL ideal_err got %0d want 0", r_err); end
    tests_run++; if (r_fidx !== 16'hFFFF) begin fails++; $display("FAIL ideal_fidx got %h want ffff", r_fidx); end
    tests_run++; if (b34 !== 1'b1 || b35 !== 1'b0) begin fails++; $display("FAIL ideal_busy got %b%b want 10", b34, b35); end
    tests_run++; if (pass !== 1'b1) begin fails++; $display("FAIL ideal_pass_held got %b want 1", pass); end
  endtask

  task automatic test_inverting();
    mode = 1;
    run_test('0, 1'b0);
    mode = 0;
    tests_run++; if (r_err !== 8'd32) begin fails++; $display("FAIL inv_err got %0d want 32", r_err); end
    tests_run++; if (r_pass !== 1'b0) begin fails++; $display("FAIL inv_pass got %b want 0", r_pass); end
    tests_run++; if (r_fidx !== 16'd0) begin fails++; $display("FAIL inv_fidx got %0d want 0", r_fidx); end
    tests_run++; if (r_err4 !== 4'd15) begin fails++; $display("FAIL inv_err_sat got %0d want 15", r_err4); end
    tests_run++; if (r_pass4 !== 1'b0) begin fails++; $display("FAIL inv_pass4 got %b want 0", r_pass4); end
  endtask

  task automatic test_stuck0();
    int ones;
    ones = popc(ref_seq());
    mode = 2;
    run_test('0, 1'b0);
    mode = 0;
    tests_run++; if (r_err !== 8'(ones)) begin fails++; $display("FAIL stuck0_err got %0d want %0d", r_err, ones); end
    tests_run++; if (r_fidx !== 16'd0) begin fails++; $display("FAIL stuck0_fidx got %0d want 0", r_fidx); end
    tests_run++; if (r_pass !== 1'b0) begin fails++; $display("FAIL stuck0_pass got %b want 0", r_pass); end
  endtask

  task automatic test_random_flips();
    logic [31:0] m;
    int cnt, first;
    mode = 0;
    for (int it = 0; it < 5; it++) begin
      if (it == 0)      m = 32'd1 << $urandom_range(0, 31);
      else if (it == 1) m = '0;
      else              m = $urandom & $urandom & $urandom;
      cnt = popc(m);
      first = -1;
      for (int k = 31; k >= 0; k--) if (m[k]) first = k;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_test(m, 1'b0);
      tests_run++; if (r_err !== 8'(cnt)) begin fails++; $display("FAIL rnd_err mask=%h got %0d want %0d", m, r_err, cnt); end
      tests_run++; if (r_err4 !== 4'((cnt > 15) ? 15 : cnt)) begin fails++; $display("FAIL rnd_err4 mask=%h got %0d", m, r_err4); end
      tests_run++; if (r_fidx !== ((first < 0) ? 16'hFFFF : 16'(first))) begin fails++; $display("FAIL rnd_fidx mask=%h got %0d want %0d", m, r_fidx, first); end
      tests_run++; if (r_pass !== (m == '0)) begin fails++; $display("FAIL rnd_pass mask=%h got %b", m, r_pass); end
    end
  endtask

  task automatic test_back_to_back();
    mode = 0;
    run_test('0, 1'b1);
    tests_run++; if (done_edge !== 35) begin fails++; $display("FAIL b2b_done_edge got %0d want 35", done_edge); end
    tests_run++; if (ndone !== 1) begin fails++; $display("FAIL b2b_ndone got %0d want 1", ndone); end
    tests_run++; if (r_pass !== 1'b1) begin fails++; $display("FAIL b2b_pass got %b want 1", r_pass); end
  endtask

  task automatic test_abort();
    int stray;
    mode = 2;   // accumulate errors before the abort so the reset is visible
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || dut_d !== 1'b0 || pass !== 1'b0)
      begin fails++; $display("FAIL abort_ctrl got busy=%b done=%b d=%b pass=%b want 0", busy, done, dut_d, pass); end
    tests_run++; if (err_count !== 8'd0 || first_err_idx !== 16'hFFFF)
      begin fails++; $display("FAIL abort_cnt got %0d/%h want 0/ffff", err_count, first_err_idx); end
    @(negedge clk); rst_n = 1'b1; mode = 0;
    stray = 0;
    repeat (3) begin @(negedge clk); if (done) stray++; end
    tests_run++; if (stray !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", stray); end
    run_test('0, 1'b0);
    tests_run++; if (done_edge !== 35 || ndone !== 1) begin fails++; $display("FAIL abort_rerun_done got %0d/%0d want 35/1", done_edge, ndone); end
    tests_run++; if (r_pass !== 1'b1) begin fails++; $display("FAIL abort_rerun_pass got %b want 1", r_pass); end
  endtask

`ifdef DFF_BIST_INJECT_EN
  task automatic test_inject();
    mode = 0;
    imask = (32'd1 << 5) | (32'd1 << 9);
    run_test('0, 1'b0);
    imask = '0;
    tests_run++; if (r_err !== 8'd2) begin fails++; $display("FAIL inject_err got %0d want 2", r_err); end
    tests_run++; if (r_fidx !== 16'd5) begin fails++; $display("FAIL inject_fidx got %0d want 5", r_fidx); end
    tests_run++; if (r_pass !== 1'b0) begin fails++; $display("FAIL inject_pass got %b want 0", r_pass); end
  endtask
`endif

  initial begin
    test_reset();
    test_ideal();
    test_inverting();
    test_stuck0();
    test_random_flips();
    test_back_to_back();
    test_abort();
`ifdef DFF_BIST_INJECT_EN
    test_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
